text_banner_renderer: RTL and testbench
=======================================

// Module: text_banner_renderer
// PURPOSE
// - Pixel-pipeline stage directly upstream of the 100x100 2-bit text-image ROM (14-bit addr, 1-cycle registered read).
// - Maps VGA DrawX/DrawY to a ROM address, consumes the returned 2-bit palette index, and emits an overlay pixel.
// - Frame-timed show/blink/hide FSM gives "FIGHT!"/"K.O."-style banners that game logic fires with a single pulse.
// PARAMETERS
// - TEXT_X        270  left edge of banner, screen px (10-bit)
// - TEXT_Y        190  top edge of banner, screen px (10-bit)
// - TEXT_W        100  image width px; ROM row stride
// - TEXT_H        100  image height px; TEXT_W*TEXT_H <= 10001
// - HOLD_FRAMES   120  steady-display frames, 1..255
// - BLINK_FRAMES   60  blinking frames after hold, 1..255
// - BLINK_PERIOD    8  frames per blink half-cycle, 1..255
// PORTS
// - Clk        in   1   system pixel clock; all state on posedge
// - Reset      in   1   asynchronous, active-high; clears all state
// - VS         in   1   VGA vsync, active-low; 1->0 edge = frame tick
// - DrawX      in  10   current pixel column
// - DrawY      in  10   current pixel row
// - show_req   in   1   1-cycle pulse: start/restart banner
// - clear      in   1   1-cycle pulse: hide immediately
// - rom_data   in   2   palette index from ROM, valid 1 cycle after rom_addr
// - rom_addr   out 14   ROM read address
// - text_on    out  1   overlay pixel opaque and visible
// - text_rgb   out 24   overlay colour {R,G,B}, 8b each
// - busy       out  1   FSM not IDLE
// BEHAVIOUR
// - Reset: rom_addr=0, text_on=0, text_rgb=0, busy=0, FSM=IDLE, counters=0, VS history reg=1.
// - Frame tick: vs_q<=VS each clk; tick = vs_q & ~VS (one cycle per frame).
// - Pipeline, inputs sampled at edge N:
//   - S1 (edge N+1): in_box = DrawX in [TEXT_X, TEXT_X+TEXT_W-1] and DrawY in [TEXT_Y, TEXT_Y+TEXT_H-1].
//     rom_addr <= in_box ? (DrawY-TEXT_Y)*TEXT_W + (DrawX-TEXT_X) : 0.
//     Math done in 14b; offsets only used when in_box, so no underflow reaches rom_addr.
//   - S2 (edge N+2): ROM presents rom_data; in_box and visible delayed to match.
//   - S3 (edge N+3): text_on <= in_box_d2 & visible_d2 & (rom_data!=0); text_rgb <= PALETTE[rom_data] if text_on else 0.
//   - Total latency DrawX/Y -> text_on/text_rgb = 3 clocks; the VGA mux compensates.
// - Palette index: 0 transparent; 1,2,3 -> PAL1/PAL2/PAL3 from package.
// - FSM states: IDLE, SHOW, BLINK; 8-bit frame counter fcnt, 8-bit phase counter pcnt, blink_on bit.
//   - IDLE: visible=0; show_req -> SHOW, fcnt=HOLD_FRAMES.
//   - SHOW: visible=1; on tick fcnt--; tick with fcnt==1 -> BLINK, fcnt=BLINK_FRAMES, pcnt=BLINK_PERIOD, blink_on=1.
//   - BLINK: visible=blink_on; on tick fcnt-- and pcnt--; pcnt reaching 0 toggles blink_on and reloads BLINK_PERIOD; tick with fcnt==1 -> IDLE.
//   - show_req in SHOW/BLINK restarts SHOW with fcnt=HOLD_FRAMES.
//   - Priority: clear > show_req > tick; clear in any state -> IDLE next edge.
//   - show_req coincident with tick: show_req wins, tick ignored that cycle.
// - visible changes only at clock edges; a mid-frame change may split one frame (acceptable).
// - Reset mid-frame or mid-banner: outputs go to reset values immediately (async), no residual pixels.
// - busy = (state != IDLE), registered with state.
// STRUCTURE
// - text_pkg: state enum {IDLE,SHOW,BLINK}; PAL1=24'hFFD700, PAL2=24'hC00000, PAL3=24'h000000; TEXT_ADDR_W=14.
// - One sub-module text_banner_timer: FSM + tick detect, outputs visible and busy.
// - Top holds address generation, 3-stage pixel pipeline and palette lookup.
// TESTING
// - Bench: behavioural 10001x2 ROM with 1-clk registered read; VS generator with short frames.
// - Reset: assert Reset mid-run -> text_on=0, text_rgb=0, rom_addr=0, busy=0 same cycle, no clock needed.
// - Address map, banner SHOW:
//   - DrawX=270,DrawY=190 -> rom_addr=0 at N+1.
//   - DrawX=369,DrawY=289 -> rom_addr=9999.
//   - DrawX=269 -> rom_addr=0 and text_on=0 at N+3.
// - Latency/palette: ROM[0]=2, pixel(270,190) -> text_rgb=24'hC00000, text_on=1 exactly 3 clks later.
//   ROM[1]=0 -> text_on=0, text_rgb=0.
// - Timing, HOLD=3,BLINK=4,PERIOD=2:
//   - show_req -> SHOW for 3 ticks, then BLINK.
//   - visible 1,1,0,0 over 4 frames, then IDLE, busy=0.
// - Restart/clear:
//   - show_req during BLINK -> SHOW, fcnt=HOLD.
//   - clear and show_req same cycle -> IDLE.
//   - show_req coincident with tick -> fcnt=HOLD, not HOLD-1.

Source files
------------

// File: rtl/text_banner_renderer_pkg.sv
// rtl/text_banner_renderer_pkg.sv - shared types, palette and widths for the text banner renderer
package text_pkg;

    localparam int TEXT_ADDR_W = 14;

    localparam logic [23:0] PAL1 = 24'hFFD700;
    localparam logic [23:0] PAL2 = 24'hC00000;
    localparam logic [23:0] PAL3 = 24'h000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLINK = 2'd2
    } state_t;

    // Index 0 is transparent; the caller masks it out with text_on.
    function automatic logic [23:0] palette(input logic [1:0] idx);
        case (idx)
            2'd1:    palette = PAL1;
            2'd2:    palette = PAL2;
            2'd3:    palette = PAL3;
            default: palette = 24'h000000;
        endcase
    endfunction

endpackage

// File: rtl/text_banner_renderer_if.sv
// rtl/text_banner_renderer_if.sv - ROM read bus between the renderer and the text-image ROM
interface text_banner_renderer_if;
    import text_pkg::*;

    logic [TEXT_ADDR_W-1:0] rom_addr;
    logic [1:0]             rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/text_banner_renderer_timer.sv
// rtl/text_banner_renderer_timer.sv - frame-timed show/blink/hide FSM with vsync tick detect
module text_banner_timer
    import text_pkg::*;
#(
    parameter int HOLD_FRAMES  = 120,
    parameter int BLINK_FRAMES = 60,
    parameter int BLINK_PERIOD = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic vs,
    input  logic show_req,
    input  logic clear,
    output logic visible,
    output logic busy
);

    localparam logic [7:0] HOLD_N   = 8'(HOLD_FRAMES);
    localparam logic [7:0] BLINK_N  = 8'(BLINK_FRAMES);
    localparam logic [7:0] PERIOD_N = 8'(BLINK_PERIOD);

    state_t     state, state_n;
    logic [7:0] fcnt, fcnt_n;
    logic [7:0] pcnt, pcnt_n;
    logic       blink_on, blink_on_n;
    logic       vs_q;
    logic       tick;

    // Falling edge of the active-low vsync marks one frame.
    assign tick = vs_q & ~vs;

    // State, counters and vsync history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q     <= 1'b1;
            state    <= IDLE;
            fcnt     <= 8'd0;
            pcnt     <= 8'd0;
            blink_on <= 1'b0;
        end else begin
            vs_q     <= vs;
            state    <= state_n;
            fcnt     <= fcnt_n;
            pcnt     <= pcnt_n;
            blink_on <= blink_on_n;
        end
    end

    // Next-state: clear beats show_req, show_req beats the frame tick.
    always_comb begin
        state_n    = state;
        fcnt_n     = fcnt;
        pcnt_n     = pcnt;
        blink_on_n = blink_on;
        if (clear) begin
            state_n = IDLE;
        end else if (show_req) begin
            state_n = SHOW;
            fcnt_n  = HOLD_N;
        end else if (tick) begin
            case (state)
                SHOW: begin
                    if (fcnt == 8'd1) begin
                        state_n    = BLINK;
                        fcnt_n     = BLINK_N;
                        pcnt_n     = PERIOD_N;
                        blink_on_n = 1'b1;
                    end else begin
                        fcnt_n = fcnt - 8'd1;
                    end
                end
                BLINK: begin
                    if (fcnt == 8'd1) begin
                        state_n = IDLE;
                    end else begin
                        fcnt_n = fcnt - 8'd1;
                        if (pcnt == 8'd1) begin
                            blink_on_n = ~blink_on;
                            pcnt_n     = PERIOD_N;
                        end else begin
                            pcnt_n = pcnt - 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign visible = (state == SHOW) | ((state == BLINK) & blink_on);
    assign busy    = (state != IDLE);

endmodule

// File: rtl/text_banner_renderer.sv
// rtl/text_banner_renderer.sv - banner overlay: address generation, 3-stage pixel pipeline, palette
module text_banner_renderer
    import text_pkg::*;
#(
    parameter int TEXT_X       = 270,
    parameter int TEXT_Y       = 190,
    parameter int TEXT_W       = 100,
    parameter int TEXT_H       = 100,
    parameter int HOLD_FRAMES  = 120,
    parameter int BLINK_FRAMES = 60,
    parameter int BLINK_PERIOD = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        VS,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        show_req,
    input  logic        clear,
    output logic        text_on,
    output logic [23:0] text_rgb,
    output logic        busy,
    text_banner_renderer_if.master rom
);

    localparam logic [10:0] X_LO = 11'(TEXT_X);
    localparam logic [10:0] X_HI = 11'(TEXT_X + TEXT_W - 1);
    localparam logic [10:0] Y_LO = 11'(TEXT_Y);
    localparam logic [10:0] Y_HI = 11'(TEXT_Y + TEXT_H - 1);

    logic                   visible;
    logic                   in_box;
    logic [TEXT_ADDR_W-1:0] dx, dy, addr_next;
    logic                   in_box_d1, in_box_d2;
    logic                   vis_d1, vis_d2;
    logic                   on_next;

    text_banner_timer #(
        .HOLD_FRAMES  (HOLD_FRAMES),
        .BLINK_FRAMES (BLINK_FRAMES),
        .BLINK_PERIOD (BLINK_PERIOD)
    ) u_timer (
        .clk      (Clk),
        .rst      (Reset),
        .vs       (VS),
        .show_req (show_req),
        .clear    (clear),
        .visible  (visible),
        .busy     (busy)
    );

    // Offsets wrap outside the box, but the address is forced to 0 there.
    assign in_box    = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} <= X_HI) &&
                       ({1'b0, DrawY} >= Y_LO) && ({1'b0, DrawY} <= Y_HI);
    assign dx        = TEXT_ADDR_W'(DrawX) - TEXT_ADDR_W'(TEXT_X);
    assign dy        = TEXT_ADDR_W'(DrawY) - TEXT_ADDR_W'(TEXT_Y);
    assign addr_next = dy * TEXT_ADDR_W'(TEXT_W) + dx;
    assign on_next   = in_box_d2 & vis_d2 & (rom.rom_data != 2'd0);

    // S1 address/box, S2 alignment with ROM latency, S3 palette output.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom.rom_addr <= '0;
            in_box_d1    <= 1'b0;
            in_box_d2    <= 1'b0;
            vis_d1       <= 1'b0;
            vis_d2       <= 1'b0;
            text_on      <= 1'b0;
            text_rgb     <= 24'h000000;
        end else begin
            rom.rom_addr <= in_box ? addr_next : '0;
            in_box_d1    <= in_box;
            vis_d1       <= visible;
            in_box_d2    <= in_box_d1;
            vis_d2       <= vis_d1;
            text_on      <= on_next;
            text_rgb     <= on_next ? palette(rom.rom_data) : 24'h000000;
        end
    end

endmodule

// File: tb/tb_text_banner_renderer.sv
// tb/tb_text_banner_renderer.sv - directed self-checking bench for text_banner_renderer
module tb_text_banner_renderer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vs = 1'b1;
    logic [9:0]  draw_x = 10'd0;
    logic [9:0]  draw_y = 10'd0;
    logic        show_req = 1'b0;
    logic        clear = 1'b0;
    logic        text_on;
    logic [23:0] text_rgb;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    text_banner_renderer_if rom_if ();

    logic [1:0] mem [0:10000];
    logic [1:0] rom_q = 2'd0;

    always #5 clk = ~clk;

    // Behavioural ROM with one-clock registered read.
    always @(posedge clk) rom_q <= mem[rom_if.rom_addr];
    assign rom_if.rom_data = rom_q;

    text_banner_renderer #(
        .HOLD_FRAMES  (3),
        .BLINK_FRAMES (4),
        .BLINK_PERIOD (2)
    ) dut (
        .Clk      (clk),
        .Reset    (rst),
        .VS       (vs),
        .DrawX    (draw_x),
        .DrawY    (draw_y),
        .show_req (show_req),
        .clear    (clear),
        .text_on  (text_on),
        .text_rgb (text_rgb),
        .busy     (busy),
        .rom      (rom_if.master)
    );

    typedef struct {
        int          x;
        int          y;
        int          addr;
        logic        on;
        logic [23:0] rgb;
    } pix_vec_t;

    pix_vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_pix(input int x, input int y);
        @(negedge clk);
        draw_x = 10'(x);
        draw_y = 10'(y);
    endtask

    task automatic pulse_show();
        @(negedge clk);
        show_req = 1'b1;
        @(negedge clk);
        show_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_clear(input logic with_show);
        @(negedge clk);
        clear = 1'b1;
        show_req = with_show;
        @(negedge clk);
        clear = 1'b0;
        show_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame(input logic with_show);
        @(negedge clk);
        vs = 1'b0;
        show_req = with_show;
        @(negedge clk);
        vs = 1'b1;
        show_req = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    logic exp_on_seq [7];
    logic exp_busy_seq [7];

    initial begin
        for (int i = 0; i <= 10000; i++) mem[i] = 2'd1;
        mem[0]    = 2'd2;
        mem[1]    = 2'd0;
        mem[105]  = 2'd2;
        mem[9999] = 2'd3;

        vecs[0]  = '{270, 190, 0,    1'b1, 24'hC00000};
        vecs[1]  = '{271, 190, 1,    1'b0, 24'h000000};
        vecs[2]  = '{369, 289, 9999, 1'b1, 24'h000000};
        vecs[3]  = '{269, 190, 0,    1'b0, 24'h000000};
        vecs[4]  = '{370, 190, 0,    1'b0, 24'h000000};
        vecs[5]  = '{270, 189, 0,    1'b0, 24'h000000};
        vecs[6]  = '{270, 290, 0,    1'b0, 24'h000000};
        vecs[7]  = '{300, 200, 1030, 1'b1, 24'hFFD700};
        vecs[8]  = '{275, 191, 105,  1'b1, 24'hC00000};
        vecs[9]  = '{0,   0,   0,    1'b0, 24'h000000};
        vecs[10] = '{1023, 1023, 0,  1'b0, 24'h000000};

        exp_on_seq   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_busy_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        #1;
        chk("reset_text_on", 32'(text_on), 32'd0);
        chk("reset_text_rgb", 32'(text_rgb), 32'd0);
        chk("reset_rom_addr", 32'(rom_if.rom_addr), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Banner idle: address still generated, but nothing drawn.
        set_pix(270, 190);
        repeat (4) @(negedge clk);
        chk("idle_addr", 32'(rom_if.rom_addr), 32'd0);
        chk("idle_text_on", 32'(text_on), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        pulse_show();
        chk("show_busy", 32'(busy), 32'd1);

        for (int i = 0; i < 11; i++) begin
            set_pix(vecs[i].x, vecs[i].y);
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("vec%0d_addr", i), 32'(rom_if.rom_addr), 32'(vecs[i].addr));
            chk($sformatf("vec%0d_on", i), 32'(text_on), 32'(vecs[i].on));
            chk($sformatf("vec%0d_rgb", i), 32'(text_rgb), 32'(vecs[i].rgb));
        end

        // Exact 3-clock latency for a single in-box pixel.
        set_pix(0, 0);
        repeat (4) @(negedge clk);
        set_pix(270, 190);
        @(posedge clk); #1;
        chk("lat_addr_n1", 32'(rom_if.rom_addr), 32'd0);
        chk("lat_on_n1", 32'(text_on), 32'd0);
        @(negedge clk);
        draw_x = 10'd0;
        draw_y = 10'd0;
        @(posedge clk); #1;
        chk("lat_on_n2", 32'(text_on), 32'd0);
        @(posedge clk); #1;
        chk("lat_on_n3", 32'(text_on), 32'd1);
        chk("lat_rgb_n3", 32'(text_rgb), 32'hC00000);
        @(posedge clk); #1;
        chk("lat_on_n4", 32'(text_on), 32'd0);

        // Full show/blink/hide timeline observed on pixel (270,190).
        pulse_clear(1'b0);
        set_pix(270, 190);
        pulse_show();
        chk("tl_start_on", 32'(text_on), 32'd1);
        chk("tl_start_busy", 32'(busy), 32'd1);
        for (int t = 0; t < 7; t++) begin
            frame(1'b0);
            chk($sformatf("tl_tick%0d_on", t + 1), 32'(text_on), 32'(exp_on_seq[t]));
            chk($sformatf("tl_tick%0d_busy", t + 1), 32'(busy), 32'(exp_busy_seq[t]));
        end

        // Restart during BLINK while hidden: full HOLD+BLINK runs again.
        pulse_show();
        repeat (5) frame(1'b0);
        chk("rs_blink_off", 32'(text_on), 32'd0);
        pulse_show();
        chk("rs_restart_on", 32'(text_on), 32'd1);
        repeat (6) frame(1'b0);
        chk("rs_tick6_busy", 32'(busy), 32'd1);
        frame(1'b0);
        chk("rs_tick7_busy", 32'(busy), 32'd0);

        // Clear wins over a coincident show_req.
        pulse_show();
        pulse_clear(1'b1);
        chk("clr_show_busy", 32'(busy), 32'd0);
        chk("clr_show_on", 32'(text_on), 32'd0);

        // Clear alone from SHOW.
        pulse_show();
        pulse_clear(1'b0);
        chk("clr_busy", 32'(busy), 32'd0);

        // show_req on a tick reloads HOLD without consuming that tick.
        pulse_show();
        frame(1'b0);
        frame(1'b1);
        repeat (6) frame(1'b0);
        chk("coin_tick6_busy", 32'(busy), 32'd1);
        frame(1'b0);
        chk("coin_tick7_busy", 32'(busy), 32'd0);

        // Asynchronous reset while a banner pixel is being drawn.
        pulse_show();
        chk("pre_reset_on", 32'(text_on), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_on", 32'(text_on), 32'd0);
        chk("async_rst_rgb", 32'(text_rgb), 32'd0);
        chk("async_rst_addr", 32'(rom_if.rom_addr), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_on", 32'(text_on), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
